// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with a one-byte valid/ready holding register
//
// Recovers 8N1 frames from an asynchronous serial line. Build with
// UART_RX_PARITY_EN defined to expect 8E1 frames and get rx_parity_err.
//
// Parameters:
//   CLKS_PER_BIT  rx_clk cycles per bit (>= 4)
//   HALF_BIT      cycles from start-edge detection to the start-bit mid-sample
// Ports:
//   rx_clk         system clock, rising edge
//   rx_rst         asynchronous active-high reset
//   rx_serial      asynchronous serial input, idles high
//   rx_ready       downstream accepts the held byte this cycle
//   rx_data        last received byte (LSB first on the wire)
//   rx_valid       rx_data holds an unaccepted byte
//   rx_frame_err   one-cycle pulse: stop bit sampled low
//   rx_overrun     one-cycle pulse: completed byte dropped, holding register full
//   rx_parity_err  one-cycle pulse: even-parity mismatch (UART_RX_PARITY_EN only)

module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  input  logic       rx_serial,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic [1:0]    sync_q;
  logic          rxd_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  assign rxd_s = sync_q[1];

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      sync_q       <= 2'b11;
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], rx_serial};
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      // Handshake clears the holding register; a delivery later in this
      // block overrides it so a simultaneous accept+load keeps valid high.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxd_s) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            state <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxd_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= S_AFTER_DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rxd_s;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            // Reported even when the stop bit is bad; both pulses may coincide.
            rx_parity_err <= ^{shreg, par_bit};
`endif
            if (rxd_s) begin
              state <= S_IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              rx_frame_err <= 1'b1;
              state        <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Parks a held-low line here so it yields a single frame error.
        S_BREAK: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

  localparam int CPB  = 434;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Pin edge -> rxd_s low (2) -> stop mid-sample -> registered outputs (+1).
  localparam int LAT = 2 + HALF + NBITS * CPB + 1;

  logic       rx_clk = 1'b0;
  logic       rx_rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
  logic       bad_parity = 1'b0;
`endif

  uart_rx dut (
    .rx_clk       (rx_clk),
    .rx_rst       (rx_rst),
    .rx_serial    (rx_serial),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  // Event log, sampled on the falling edge.
  int         rise_cnt, rise_cyc, ferr_cnt, ferr_cyc, ovr_cnt, ovr_cyc, valid_cycles, par_cnt;
  logic [7:0] rise_data;
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       ready_at_edge = 1'b1;

  always @(posedge rx_clk) ready_at_edge = rx_ready;

  always @(negedge rx_clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = rx_data;
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
    end
    if (rx_valid) valid_cycles++;
    if (rx_frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
    if (rx_overrun) begin ovr_cnt++; ovr_cyc = cyc; end
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) par_cnt++;
`endif
    if (prev_valid && !ready_at_edge && !rx_rst) begin
      checks++;
      if (!rx_valid || rx_data != prev_data) begin
        errors++;
        $display("FAIL held_stable: valid=%0b data=%02h, required valid=1 data=%02h",
                 rx_valid, rx_data, prev_data);
      end
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  task automatic clear_mon();
    rise_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; valid_cycles = 0; par_cnt = 0;
    rise_cyc = -1; ferr_cyc = -1; ovr_cyc = -1;
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge with the line high.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int st);
    st = cyc;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge rx_clk);
    for (int k = 0; k < 8; k++) begin
      rx_serial = d[k];
      repeat (CPB) @(negedge rx_clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_serial = (^d) ^ bad_parity;
    repeat (CPB) @(negedge rx_clk);
`endif
    rx_serial = stop;
    repeat (CPB) @(negedge rx_clk);
    rx_serial = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_rise;
    int         exp_ferr;
  } vec_t;

  vec_t       tbl[4];
  int         st, st2;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  initial begin
    tbl[0] = '{8'h72, 1'b1, 8'h72, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    tbl[3] = '{8'hC6, 1'b0, 8'hFF, 0, 1};
    clear_mon();

    // Reset values, during and after reset.
    repeat (3) @(negedge rx_clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    rx_rst = 1'b0;
    repeat (5) @(negedge rx_clk);
    check("post_rst_valid", rx_valid, 0);

    // Table-driven frames with rx_ready held high.
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      send_frame(tbl[i].data, tbl[i].stop, st);
      repeat (CPB) @(negedge rx_clk);
      check("tbl_rise_n", rise_cnt, tbl[i].exp_rise);
      if (tbl[i].exp_rise != 0) check("tbl_rise_cyc", rise_cyc, st + LAT);
      check("tbl_ferr_n", ferr_cnt, tbl[i].exp_ferr);
      if (tbl[i].exp_ferr != 0) check("tbl_ferr_cyc", ferr_cyc, st + LAT);
      check("tbl_data", rx_data, tbl[i].exp_data);
      check("tbl_valid_cycles", valid_cycles, tbl[i].exp_rise);
      check("tbl_ovr_n", ovr_cnt, 0);
    end

    // 100-cycle glitch: false start, nothing reported.
    clear_mon();
    rx_serial = 1'b0;
    repeat (100) @(negedge rx_clk);
    rx_serial = 1'b1;
    repeat (600) @(negedge rx_clk);
    check("glitch_rise_n", rise_cnt, 0);
    check("glitch_ferr_n", ferr_cnt, 0);
    check("glitch_ovr_n", ovr_cnt, 0);

    // Bad stop bit followed by a long break, then a clean frame.
    clear_mon();
    send_frame(8'h55, 1'b0, st);
    rx_serial = 1'b0;
    repeat (5000) @(negedge rx_clk);
    rx_serial = 1'b1;
    repeat (CPB) @(negedge rx_clk);
    check("brk_ferr_n", ferr_cnt, 1);
    check("brk_ferr_cyc", ferr_cyc, st + LAT);
    check("brk_rise_n", rise_cnt, 0);
    check("brk_valid", rx_valid, 0);
    send_frame(8'hA3, 1'b1, st);
    repeat (CPB) @(negedge rx_clk);
    check("brk_next_rise_n", rise_cnt, 1);
    check("brk_next_data", rise_data, 8'hA3);
    check("brk_next_cyc", rise_cyc, st + LAT);
    check("brk_ferr_total", ferr_cnt, 1);

    // Overrun: rx_ready low across two back-to-back frames.
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, st);
    send_frame(8'h22, 1'b1, st2);
    repeat (50) @(negedge rx_clk);
    check("ovr_rise_n", rise_cnt, 1);
    check("ovr_rise_cyc", rise_cyc, st + LAT);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1);
    check("ovr_n", ovr_cnt, 1);
    check("ovr_cyc", ovr_cyc, st2 + LAT);
    check("ovr_ferr_n", ferr_cnt, 0);
    rx_ready = 1'b1;
    @(negedge rx_clk);
    check("accept_valid", rx_valid, 0);
    check("accept_data_kept", rx_data, 8'h11);

    // Reset in the middle of data bit 4 of 0xFF.
    clear_mon();
    rx_serial = 1'b0;
    repeat (CPB) @(negedge rx_clk);
    rx_serial = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge rx_clk);
    rx_rst = 1'b1;
    repeat (3) @(negedge rx_clk);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_ferr", rx_frame_err, 0);
    check("midrst_ovr", rx_overrun, 0);
    rx_rst = 1'b0;
    repeat (2 * CPB) @(negedge rx_clk);
    check("midrst_rise_n", rise_cnt, 0);
    check("midrst_ferr_n", ferr_cnt, 0);
    send_frame(8'h3C, 1'b1, st);
    repeat (CPB) @(negedge rx_clk);
    check("midrst_next_rise_n", rise_cnt, 1);
    check("midrst_next_data", rise_data, 8'h3C);
    check("midrst_next_cyc", rise_cyc, st + LAT);
    check("midrst_next_flags", ferr_cnt + ovr_cnt, 0);

`ifdef UART_RX_PARITY_EN
    clear_mon();
    bad_parity = 1'b1;
    send_frame(8'h07, 1'b1, st);
    repeat (CPB) @(negedge rx_clk);
    check("par_bad_n", par_cnt, 1);
    check("par_bad_rise_n", rise_cnt, 1);
    check("par_bad_data", rise_data, 8'h07);
    clear_mon();
    bad_parity = 1'b0;
    send_frame(8'h07, 1'b1, st);
    repeat (CPB) @(negedge rx_clk);
    check("par_good_n", par_cnt, 0);
    check("par_good_rise_n", rise_cnt, 1);
`endif

    // Random bytes with random idle gaps (including zero) against a queue model.
    clear_mon();
    exp_q.delete();
    exp_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge rx_clk);
      send_frame(d, 1'b1, st);
      exp_q.push_back(d);
      exp_cyc_q.push_back(st + LAT);
    end
    repeat (CPB) @(negedge rx_clk);
    check("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check("rnd_data", got_q[i], exp_q[i]);
        check("rnd_cyc", got_cyc_q[i], exp_cyc_q[i]);
      end
    end
    check("rnd_flags", ferr_cnt + ovr_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the FPGA UART link. It is the consumer of the line driven by the UART transmitter. It oversamples the incoming serial line in the system clock domain, recovers 8N1 frames (optionally 8E1), and presents each received byte to downstream logic through a one-byte valid/ready holding register. Error and overrun flags are reported per frame.

## Interface

- `CLKS_PER_BIT`, default 434: rx_clk cycles per bit. 50 MHz / 115 200 baud. Must be ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (217): cycles from start-edge detection to the start-bit mid-sample.
- `rx_clk`, input, 1: system clock (50 MHz). All logic runs on its rising edge.
- `rx_rst`, input, 1: asynchronous, active-high reset.
- `rx_serial`, input, 1: asynchronous serial line. Idles high.
- `rx_ready`, input, 1: downstream accepts the held byte in this cycle.
- `rx_data`, output, 8: last received byte, LSB first on the wire.
- `rx_valid`, output, 1: `rx_data` holds an unaccepted byte.
- `rx_frame_err`, output, 1: one-cycle pulse; stop bit was sampled low.
- `rx_overrun`, output, 1: one-cycle pulse; a completed byte was dropped.
- `rx_parity_err`, output, 1: one-cycle pulse; parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation

- `rx_serial` passes through a 2-FF synchronizer, initialised to 1 on reset, to give `rxd_s`. Only `rxd_s` is used by the FSM.
- The FSM has states IDLE, START, DATA, PARITY (macro only), STOP and BREAK. A single counter `cnt` (0..CLKS_PER_BIT-1) and a bit index `idx` (0..7) are shared across states.
- IDLE: `cnt` is held at 0. When `rxd_s == 0`, go to START.
- START: when `cnt == HALF_BIT-1`, sample `rxd_s`:
  - If the sample is 0, clear `cnt` and `idx` and go to DATA.
  - If the sample is 1, it was a false start: go to IDLE with no flags.
- DATA: when `cnt == CLKS_PER_BIT-1`, shift `rxd_s` into bit `idx` of the shift register and clear `cnt`.
  - When `idx == 7`, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: when `cnt == CLKS_PER_BIT-1`, capture the parity bit and go to STOP.
- STOP: when `cnt == CLKS_PER_BIT-1`, sample `rxd_s`:
  - If the sample is 1, the frame is good: deliver the byte and go to IDLE.
  - If the sample is 0, pulse `rx_frame_err`, do not deliver the byte, and go to BREAK.
- BREAK: wait until `rxd_s == 1`, then go to IDLE. A held-low line therefore produces exactly one `rx_frame_err`.
- Byte delivery:
  - If `rx_valid == 0`, or `rx_ready == 1` in the same cycle: load `rx_data`, set `rx_valid`.
  - Otherwise: keep the old `rx_data`, keep `rx_valid` high, and pulse `rx_overrun`.
- A handshake completes when `rx_ready && rx_valid`. On the next edge `rx_valid` clears, unless a new byte is delivered in that same cycle, in which case it stays high.
- `rx_data` is stable whenever `rx_valid` is high. It retains its value after acceptance.
- Reset values: FSM in IDLE, `cnt = 0`, `idx = 0`, `rx_data = 8'h00`, `rx_valid = 0`, all flag pulses 0, synchronizer bits at 1.
- A reset asserted mid-frame aborts the frame immediately. No flags are produced. Reception resumes on the next falling edge after release.

## Timing

- Let t0 be the first cycle in which `rxd_s` is low. t0 is 2–3 rx_clk cycles after the pin edge.
- Sample points:
  - start bit: t0 + HALF_BIT
  - data bit k: t0 + HALF_BIT + (k+1)·CLKS_PER_BIT
  - stop bit (8N1): t0 + HALF_BIT + 9·CLKS_PER_BIT
- `rx_valid` rises, and any flag pulse occurs, one cycle after the stop sample. For the defaults this is t0 + 4124.
- With parity enabled, the stop sample moves one bit period later.
- Back-to-back frames are supported. A start edge arriving in the first cycle after returning to IDLE is detected.
- Tolerated baud mismatch is about ±4% under mid-bit sampling.
- There is no combinational path from `rx_ready` to any output.

## Configuration

- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - An even-parity bit is expected between D7 and STOP, handled by the PARITY state.
  - `rx_parity_err` pulses in the delivery cycle when the XOR of the data bits and the parity bit is 1.
  - The byte is still delivered. Frame error takes precedence: no delivery, but both pulses may occur.
- Undefined:
  - The PARITY state and the `rx_parity_err` port do not exist.
  - The frame is 8N1.

## Test plan

- Send 0x72 as 8N1 at 434 cycles/bit with `rx_ready` held high. Expect `rx_valid` to rise at t0+4124 with `rx_data = 0x72`, clear the next cycle, and no flags.
- Drive a 100-cycle low glitch on an idle line. Expect the FSM to return to IDLE; no `rx_valid` and no flags.
- Send 0x55 with the stop bit forced low, then hold the line low for 5000 cycles. Expect one `rx_frame_err` pulse, `rx_valid` to stay 0, and a correct subsequent 0xA3 after the line returns high.
- Hold `rx_ready` at 0 and send 0x11 then 0x22 back-to-back. Expect `rx_data = 0x11` held, one `rx_overrun` pulse, and `rx_data` unchanged after the 0x22 frame.
- Assert `rx_rst` during data bit 4 of 0xFF, then send 0x3C. Expect all outputs at reset values, no flags, and 0x3C received correctly.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0. Expect `rx_data = 0x07`, `rx_valid` set, and one `rx_parity_err` pulse. Send 0x07 with parity bit 1: expect no error.
